// File: rtl/axi_stream_pckg.sv
// Shared definitions for the AXI4-Stream transmit path.
// Holds the stream/FIFO geometry, the sample and frame sizes shared with the
// FFT core, and the transmitter FSM state type.
package axi_stream_pckg;

    localparam int unsigned C_SAMPLE_WDT    = 16;
    localparam int unsigned C_FFT_SIZE_LOG2 = 10;
    localparam int unsigned M_TDATA_WDT     = 2 * C_SAMPLE_WDT;
    localparam int unsigned M_FIFO_ADDR_WDT = 3;
    localparam int unsigned M_FIFO_SIZE     = 1 << M_FIFO_ADDR_WDT;

    typedef enum logic [1:0] {
        M_IDLE,
        M_READ,
        M_DRAIN,
        M_DONE
    } m_tx_state;

endpackage

// File: rtl/axis_sync_fifo.sv
// Small synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push, din  : write request and data
//   pop        : read request; the head entry is discarded
//   dout       : head entry (valid whenever !empty)
//   full/empty : occupancy flags
//   count      : number of stored entries (0 .. 2**ADDR_WDT)
// Simultaneous push and pop keeps the occupancy unchanged. A word pushed into
// an empty FIFO shows at dout on the following cycle.
module axis_sync_fifo #(
    parameter int unsigned DATA_WDT = axi_stream_pckg::M_TDATA_WDT + 1,
    parameter int unsigned ADDR_WDT = axi_stream_pckg::M_FIFO_ADDR_WDT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic [DATA_WDT-1:0] din,
    output logic [DATA_WDT-1:0] dout,
    output logic                full,
    output logic                empty,
    output logic [ADDR_WDT:0]   count
);

    localparam int unsigned DEPTH = 1 << ADDR_WDT;
    localparam logic [ADDR_WDT:0]   CNT_FULL = {1'b1, {ADDR_WDT{1'b0}}};
    localparam logic [ADDR_WDT:0]   CNT_ONE  = {{ADDR_WDT{1'b0}}, 1'b1};
    localparam logic [ADDR_WDT-1:0] PTR_ONE  = {{(ADDR_WDT-1){1'b0}}, 1'b1};

    logic [DATA_WDT-1:0] mem_q [DEPTH];
    logic [ADDR_WDT-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WDT-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WDT:0]   count_q, count_d;
    logic                do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // A push into a full FIFO is only taken when the head leaves the same cycle.
        do_push  = push && ((count_q != CNT_FULL) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign count = count_q;

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && empty));

endmodule

// File: rtl/axis_master_tx.sv
// AXI4-Stream transmitter: streams one FFT frame (2**C_FFT_SIZE_LOG2 complex
// samples) from the result memory to the M_AXIS sink.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   M_AXIS_TDATA/TLAST  : beat payload {re, im} and end-of-frame flag
//   M_AXIS_TVALID/TREADY: stream handshake
//   m_axis_if_addr/rd_en: result memory read port (data returns 1 cycle later)
//   data_re_0_out/im    : memory read data
//   tx_start            : frame-ready pulse, ignored while s_axis_if_busy
//   s_axis_if_busy      : receive path active
//   m_axis_if_busy      : transmitter active (state != M_IDLE)
//   tx_done             : one-cycle pulse after the last beat handshake
// Build option: define M_AXIS_BITREV_EN to address the memory with the
// bit-reversed read index (natural-order output from a bit-reversed memory).
module axis_master_tx #(
    parameter int unsigned C_SAMPLE_WDT    = axi_stream_pckg::C_SAMPLE_WDT,
    parameter int unsigned C_FFT_SIZE_LOG2 = axi_stream_pckg::C_FFT_SIZE_LOG2,
    parameter int unsigned M_TDATA_WDT     = axi_stream_pckg::M_TDATA_WDT,
    parameter int unsigned M_FIFO_ADDR_WDT = axi_stream_pckg::M_FIFO_ADDR_WDT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [M_TDATA_WDT-1:0]     M_AXIS_TDATA,
    output logic                       M_AXIS_TLAST,
    output logic                       M_AXIS_TVALID,
    input  logic                       M_AXIS_TREADY,
    output logic [C_FFT_SIZE_LOG2-1:0] m_axis_if_addr,
    output logic                       m_axis_if_rd_en,
    input  logic [C_SAMPLE_WDT-1:0]    data_re_0_out,
    input  logic [C_SAMPLE_WDT-1:0]    data_im_0_out,
    input  logic                       tx_start,
    input  logic                       s_axis_if_busy,
    output logic                       m_axis_if_busy,
    output logic                       tx_done
);

    import axi_stream_pckg::*;

    localparam logic [C_FFT_SIZE_LOG2-1:0] LAST_IDX = '1;
    localparam logic [C_FFT_SIZE_LOG2-1:0] IDX_ONE  = {{(C_FFT_SIZE_LOG2-1){1'b0}}, 1'b1};
    localparam logic [M_FIFO_ADDR_WDT+1:0] DEPTH_L  = {2'b01, {M_FIFO_ADDR_WDT{1'b0}}};

    m_tx_state                  state_q, state_d;
    logic [C_FFT_SIZE_LOG2-1:0] rd_idx_q, rd_idx_d;
    logic                       inflight_q, inflight_d;
    logic                       last_q, last_d;
    logic                       rd_en;

    logic [M_FIFO_ADDR_WDT:0]   fifo_count;
    logic                       fifo_full, fifo_empty;
    logic                       fifo_push, fifo_pop;
    logic [M_TDATA_WDT:0]       fifo_din, fifo_dout;
    logic [M_FIFO_ADDR_WDT+1:0] credit_used;

    // Entries already stored plus the word still on its way back from memory.
    assign credit_used = {1'b0, fifo_count} + {{(M_FIFO_ADDR_WDT+1){1'b0}}, inflight_q};

    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        rd_en    = 1'b0;
        tx_done  = 1'b0;
        case (state_q)
            M_IDLE: begin
                if (tx_start && !s_axis_if_busy) begin
                    state_d  = M_READ;
                    rd_idx_d = '0;
                end
            end
            M_READ: begin
                if (credit_used < DEPTH_L) begin
                    rd_en    = 1'b1;
                    rd_idx_d = rd_idx_q + IDX_ONE;
                    if (rd_idx_q == LAST_IDX) begin
                        state_d = M_DRAIN;
                    end
                end
            end
            M_DRAIN: begin
                if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) begin
                    state_d = M_DONE;
                end
            end
            M_DONE: begin
                tx_done = 1'b1;
                state_d = M_IDLE;
            end
            default: state_d = M_IDLE;
        endcase
    end

    always_comb begin
        inflight_d = rd_en;
        last_d     = rd_en && (rd_idx_q == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= M_IDLE;
            rd_idx_q   <= '0;
            inflight_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            inflight_q <= inflight_d;
            last_q     <= last_d;
        end
    end

`ifdef M_AXIS_BITREV_EN
    for (genvar g = 0; g < C_FFT_SIZE_LOG2; g++) begin : g_bitrev
        assign m_axis_if_addr[g] = rd_idx_q[C_FFT_SIZE_LOG2-1-g];
    end
`else
    assign m_axis_if_addr = rd_idx_q;
`endif

    assign m_axis_if_rd_en = rd_en;
    assign m_axis_if_busy  = (state_q != M_IDLE);

    // TLAST travels with its sample through the FIFO as the top bit.
    assign fifo_push = inflight_q;
    assign fifo_din  = {last_q, data_re_0_out, data_im_0_out};
    assign fifo_pop  = M_AXIS_TVALID && M_AXIS_TREADY;

    axis_sync_fifo #(
        .DATA_WDT (M_TDATA_WDT + 1),
        .ADDR_WDT (M_FIFO_ADDR_WDT)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign M_AXIS_TVALID = !fifo_empty;
    assign M_AXIS_TLAST  = fifo_dout[M_TDATA_WDT];
    assign M_AXIS_TDATA  = fifo_dout[M_TDATA_WDT-1:0];

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (M_AXIS_TVALID && !M_AXIS_TREADY) |=>
        (M_AXIS_TVALID && $stable(M_AXIS_TDATA) && $stable(M_AXIS_TLAST)));
    a_credit: assert property (@(posedge clk) disable iff (!rst_n)
        (credit_used <= DEPTH_L) && !(fifo_full && inflight_q));

endmodule

// File: tb/tb_axis_master_tx.sv
module tb_axis_master_tx;

`ifdef M_AXIS_BITREV_EN
    localparam int LOG2 = 3;
`else
    localparam int LOG2 = 10;
`endif
    localparam int N     = 1 << LOG2;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [31:0]     tdata;
    logic            tlast, tvalid, tready;
    logic [LOG2-1:0] addr;
    logic            rd_en;
    logic [31:0]     rdata;
    logic            tx_start, s_busy, busy, tx_done;

    logic [31:0] mem [N];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int tr_mode = 0;  // 0: ready high, 1: random, 2: ready low

    // Reference model state (transaction level)
    int   rd_issued, beats, done_cnt, obs_reads;
    logic rd_prev, model_busy, last_hs_prev, prev_stall, prev_last, seen_valid;
    logic [31:0] prev_data;
    int   start_neg, first_valid_neg, done_neg;

    always #5 clk = ~clk;

    axis_master_tx #(
        .C_SAMPLE_WDT    (16),
        .C_FFT_SIZE_LOG2 (LOG2),
        .M_TDATA_WDT     (32),
        .M_FIFO_ADDR_WDT (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .M_AXIS_TDATA    (tdata),
        .M_AXIS_TLAST    (tlast),
        .M_AXIS_TVALID   (tvalid),
        .M_AXIS_TREADY   (tready),
        .m_axis_if_addr  (addr),
        .m_axis_if_rd_en (rd_en),
        .data_re_0_out   (rdata[31:16]),
        .data_im_0_out   (rdata[15:0]),
        .tx_start        (tx_start),
        .s_axis_if_busy  (s_busy),
        .m_axis_if_busy  (busy),
        .tx_done         (tx_done)
    );

    // Result memory: one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) rdata <= mem[addr];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int exp_addr(input int k);
        int r;
        r = k;
`ifdef M_AXIS_BITREV_EN
        r = 0;
        for (int b = 0; b < LOG2; b++) begin
            if (k[b]) r = r | (1 << (LOG2 - 1 - b));
        end
`endif
        return r;
    endfunction

    function automatic logic [31:0] exp_word(input int k);
        logic [15:0] kk;
        kk = k[15:0];
        return {kk, ~kk};
    endfunction

    // Monitor + reference model, sampled mid-cycle
    always @(negedge clk) begin
        int   fifo_n;
        logic exp_valid, exp_rd, hs;
        cyc++;
        if (!rst_n) begin
            rd_issued = 0; beats = 0; rd_prev = 1'b0; model_busy = 1'b0;
            last_hs_prev = 1'b0; prev_stall = 1'b0; seen_valid = 1'b0;
        end else begin
            fifo_n    = rd_issued - beats - (rd_prev ? 1 : 0);
            exp_valid = (fifo_n > 0);
            exp_rd    = model_busy && (rd_issued < N) && ((rd_issued - beats) < DEPTH);
            check_eq("busy", busy, model_busy);
            check_eq("tvalid", tvalid, exp_valid);
            check_eq("rd_en", rd_en, exp_rd);
            if (rd_en) begin
                check_eq("addr", addr, exp_addr(rd_issued));
                obs_reads++;
            end
            if (tvalid) begin
                check_eq("tdata", tdata, exp_word(beats));
                check_eq("tlast", tlast, beats == N - 1);
                if (!seen_valid) first_valid_neg = cyc;
                seen_valid = 1'b1;
            end
            if (prev_stall)
                check_eq("stall_hold", {tvalid, tlast, tdata}, {1'b1, prev_last, prev_data});
            check_eq("tx_done", tx_done, model_busy && last_hs_prev);
            if (tx_done) begin
                done_cnt++;
                done_neg = cyc;
            end

            hs           = exp_valid && tready;
            prev_stall   = tvalid && !tready;
            prev_data    = tdata;
            prev_last    = tlast;
            last_hs_prev = hs && (beats == N - 1);
            if (model_busy && last_hs_prev === 1'b0 && tx_done) model_busy = 1'b0;
            if (hs) beats++;
            if (exp_rd) rd_issued++;
            rd_prev = exp_rd;
            if (tx_start && !s_busy && !model_busy) begin
                model_busy = 1'b1;
                rd_issued = 0; beats = 0; rd_prev = 1'b0;
                seen_valid = 1'b0; obs_reads = 0;
                start_neg = cyc;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        case (tr_mode)
            0: tready = 1'b1;
            1: tready = 1'($urandom % 2);
            default: tready = 1'b0;
        endcase
    endtask

    task automatic start();
        tx_start = 1'b1;
        cycle();
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input int poke_at);
        int d0, i;
        d0 = done_cnt;
        i  = 0;
        while (done_cnt == d0 && i < 20 * N + 200) begin
            if (poke_at != 0 && i == poke_at) tx_start = 1'b1;
            cycle();
            tx_start = 1'b0;
            i++;
        end
        if (done_cnt == d0) check_eq("done_timeout", 0, 1);
    endtask

    initial begin
        int seed_dummy, d0, g;
        seed_dummy = $urandom(7);
        for (int k = 0; k < N; k++) mem[exp_addr(k)] = exp_word(k);
        rst_n = 1'b0; tready = 1'b1; tx_start = 1'b0; s_busy = 1'b0;
        done_cnt = 0; obs_reads = 0;
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();
        check_eq("rst_tvalid", tvalid, 0);
        check_eq("rst_rd_en", rd_en, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_tx_done", tx_done, 0);
        check_eq("rst_addr", addr, 0);

        // Full-rate frame
        tr_mode = 0;
        start();
        wait_done(0);
        check_eq("lat_first_valid", first_valid_neg - start_neg, 3);
        check_eq("lat_tx_done", done_neg - start_neg, N + 3);

        // Random backpressure
        tr_mode = 1;
        start();
        wait_done(0);

        // Long stall right after start
        tr_mode = 2;
        start();
        repeat (50) cycle();
        check_eq("stall_reads", obs_reads, DEPTH);
        check_eq("stall_tvalid", tvalid, 1);
        check_eq("stall_beat0", tdata, exp_word(0));
        tr_mode = 0;
        wait_done(0);

        // Starts that must be ignored
        s_busy = 1'b1;
        start();
        repeat (5) cycle();
        check_eq("ign_busy", busy, 0);
        check_eq("ign_tvalid", tvalid, 0);
        s_busy = 1'b0;
        d0 = done_cnt;
        tr_mode = 1;
        start();
        wait_done(N / 2);
        repeat (5) cycle();
        check_eq("one_done", done_cnt - d0, 1);
        check_eq("idle_after", busy, 0);

        // Reset mid-frame, then a clean frame
        tr_mode = 0;
        start();
        g = 0;
        while (beats < N / 2 && g < 4 * N) begin
            cycle();
            g++;
        end
        check_eq("reached_mid", beats >= N / 2, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_tvalid", tvalid, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_rd_en", rd_en, 0);
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();
        check_eq("post_rst_tvalid", tvalid, 0);
        check_eq("post_rst_addr", addr, 0);
        d0 = done_cnt;
        start();
        wait_done(0);
        check_eq("post_rst_done", done_cnt - d0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
